// File: rtl/fabric_ccff_loader.sv
// fabric_ccff_loader: serializes host configuration words onto the fabric
// configuration flip-flop chain. For each chain bit it drives ccff_head and
// raises a single-cycle prog_clk pulse. Optional CRC-8 check of the shifted
// stream is compiled in with `define FABRIC_CCFF_LOADER_CRC_EN.
`timescale 1ns/1ps

module fabric_ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              prog_clk,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
`ifdef FABRIC_CCFF_LOADER_CRC_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

    state_t             state;
    logic               phase;     // 0: data set-up half, 1: prog_clk high half
    logic [WORD_W-1:0]  shreg;     // bits still to be shifted after ccff_head
    logic [IDX_W-1:0]   word_idx;  // index of the current bit within the word
    logic [CNT_W-1:0]   bit_cnt;   // chain bits already clocked in

    logic last_bit_of_chain;
    logic last_bit_of_word;

    assign last_bit_of_chain = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign last_bit_of_word  = (word_idx == IDX_W'(WORD_W - 1));

`ifdef FABRIC_CCFF_LOADER_CRC_EN
    logic [7:0] crc;
    logic [7:0] crc_nxt;
    logic       error_q;

    // Serial CRC-8 (x^8+x^2+x+1) step over the bit currently on ccff_head.
    assign crc_nxt = {crc[6:0], 1'b0} ^ ({8{crc[7] ^ ccff_head}} & 8'h07);
    assign error   = error_q;
`else
    assign error   = 1'b0;
`endif

    // Loader FSM: word handshake, two-phase bit slots and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every register gets <= and an async reset value, so an
            // abort mid-shift leaves no stale prog_clk pulse or half-state.
            state     <= ST_IDLE;
            phase     <= 1'b0;
            shreg     <= '0;
            word_idx  <= '0;
            bit_cnt   <= '0;
            cfg_ready <= 1'b0;
            ccff_head <= 1'b0;
            prog_clk  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef FABRIC_CCFF_LOADER_CRC_EN
            crc       <= 8'h00;
            error_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        bit_cnt   <= '0;
`ifdef FABRIC_CCFF_LOADER_CRC_EN
                        crc       <= 8'h00;
                        error_q   <= 1'b0;
`endif
                    end
                end

                ST_LOAD: begin
                    if (cfg_valid) begin
                        // Bit 0 goes straight to the head so it is stable for
                        // the whole of its phase 0.
                        ccff_head <= cfg_data[0];
                        shreg     <= cfg_data >> 1;
                        word_idx  <= '0;
                        phase     <= 1'b0;
                        cfg_ready <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (!phase) begin
                        phase    <= 1'b1;
                        prog_clk <= 1'b1;
                    end else begin
                        phase    <= 1'b0;
                        prog_clk <= 1'b0;
                        bit_cnt  <= bit_cnt + 1'b1;
`ifdef FABRIC_CCFF_LOADER_CRC_EN
                        crc      <= crc_nxt;
`endif
                        if (last_bit_of_chain) begin
`ifdef FABRIC_CCFF_LOADER_CRC_EN
                            state     <= ST_CHECK;
                            cfg_ready <= 1'b1;
`else
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else if (last_bit_of_word) begin
                            // ccff_head keeps the last bit while waiting.
                            state     <= ST_LOAD;
                            cfg_ready <= 1'b1;
                        end else begin
                            ccff_head <= shreg[0];
                            shreg     <= shreg >> 1;
                            word_idx  <= word_idx + 1'b1;
                        end
                    end
                end

`ifdef FABRIC_CCFF_LOADER_CRC_EN
                ST_CHECK: begin
                    if (cfg_valid) begin
                        error_q   <= (cfg_data[7:0] != crc);
                        state     <= ST_DONE;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_ccff_loader.sv
// tb_fabric_ccff_loader: directed + randomized checks of fabric_ccff_loader
// against a bit-list / polynomial-division reference model. Two instances:
// a 20-bit chain for the main scenarios and an 8-bit chain for done hold.
`timescale 1ns/1ps

module tb_fabric_ccff_loader;

    localparam int LA  = 20;
    localparam int LB  = 8;
    localparam int W   = 8;
    localparam int LIM = 500;
`ifdef FABRIC_CCFF_LOADER_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic         start_a = 1'b0, valid_a = 1'b0;
    logic [W-1:0] data_a  = '0;
    logic         ready_a, head_a, pclk_a, busy_a, done_a, err_a;

    logic         start_b = 1'b0, valid_b = 1'b0;
    logic [W-1:0] data_b  = '0;
    logic         ready_b, head_b, pclk_b, busy_b, done_b, err_b;

    always #5 clk = ~clk;

    fabric_ccff_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cfg_data(data_a),
        .cfg_valid(valid_a), .cfg_ready(ready_a), .ccff_head(head_a),
        .prog_clk(pclk_a), .busy(busy_a), .done(done_a), .error(err_a)
    );

    fabric_ccff_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cfg_data(data_b),
        .cfg_valid(valid_b), .cfg_ready(ready_b), .ccff_head(head_b),
        .prog_clk(pclk_b), .busy(busy_b), .done(done_b), .error(err_b)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Chain-side capture: the bit the chain sees at each prog_clk rising edge.
    bit got_a[$];
    bit got_b[$];
    always @(posedge pclk_a) got_a.push_back(head_a);
    always @(posedge pclk_b) got_b.push_back(head_b);

    // prog_clk must be a single-cycle pulse with ccff_head unchanged from phase 0.
    logic prev_pclk_a = 1'b0;
    logic prev_head_a = 1'b0;
    always @(negedge clk) begin
        if (reset && pclk_a) begin
            check("pclk_single_high", prev_pclk_a, 1'b0);
            check("head_stable_at_pulse", head_a, prev_head_a);
        end
        prev_pclk_a <= pclk_a;
        prev_head_a <= head_a;
    end

    // CRC-8 as the remainder of (message * x^8) mod 0x107, first bit = MSB.
    function automatic logic [7:0] crc8_ref(input bit bits[$]);
        logic [127:0] v;
        v = '0;
        foreach (bits[i]) v = {v[126:0], bits[i]};
        v = v << 8;
        for (int i = 127; i >= 8; i--)
            if (v[i]) v = v ^ (128'h107 << (i - 8));
        return v[7:0];
    endfunction

    logic [7:0] words_a[$];

    task automatic wait_ready_a(input string tag);
        int t = 0;
        while (!ready_a && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (!ready_a) check({tag, ":ready_timeout"}, ready_a, 1'b1);
    endtask

    task automatic wait_done_a(input string tag);
        int t = 0;
        while (!done_a && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (!done_a) check({tag, ":done_timeout"}, done_a, 1'b1);
    endtask

    // One full chain load on dut_a from words_a; optional gap after word 0,
    // optional ignored start pulse during word 1, optional corrupted CRC.
    task automatic run_load_a(input string tag, input int gap, input bit poke, input bit bad);
        bit          exp_bits[$];
        int          rem, nb, lat, r, d, base;
        logic [63:0] gv, ev;
        logic        hold;
        exp_bits = {};
        lat = 0;
        rem = LA;
        foreach (words_a[i]) begin
            nb = (rem < W) ? rem : W;
            lat += 1 + 2 * nb;
            for (int b = 0; b < nb; b++) exp_bits.push_back(words_a[i][b]);
            rem -= nb;
        end
        if (CRC_ON) lat += 1;
        base = got_a.size();

        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        check({tag, ":busy_after_start"}, busy_a, 1'b1);
        check({tag, ":ready_after_start"}, ready_a, 1'b1);
        check({tag, ":done_cleared"}, done_a, 1'b0);
        check({tag, ":error_cleared"}, err_a, 1'b0);
        r = cyc;

        data_a  = words_a[0];
        valid_a = 1'b1;
        for (int i = 0; i < words_a.size(); i++) begin
            wait_ready_a(tag);
            @(negedge clk);
            if (i + 1 < words_a.size()) begin
                data_a = words_a[i + 1];
            end else begin
`ifdef FABRIC_CCFF_LOADER_CRC_EN
                data_a = crc8_ref(exp_bits) ^ {7'd0, bad};
`else
                valid_a = 1'b0;
`endif
            end
            if (i == 0 && gap > 0) valid_a = 1'b0;
            if (poke && i == 1) begin
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end
            if (i == 0 && gap > 0) begin
                wait_ready_a(tag);
                hold = head_a;
                repeat (gap) begin
                    check({tag, ":gap_pclk_low"}, pclk_a, 1'b0);
                    check({tag, ":gap_head_hold"}, head_a, hold);
                    check({tag, ":gap_ready"}, ready_a, 1'b1);
                    @(negedge clk);
                end
                valid_a = 1'b1;
            end
        end
`ifdef FABRIC_CCFF_LOADER_CRC_EN
        wait_ready_a({tag, ":crc"});
        @(negedge clk);
        valid_a = 1'b0;
`endif

        wait_done_a(tag);
        d = cyc;
        if (gap == 0) check({tag, ":done_latency"}, d - r, lat);
        check({tag, ":pulse_count"}, got_a.size() - base, LA);
        gv = '0;
        ev = '0;
        for (int i = 0; i < LA && base + i < got_a.size(); i++) gv[i] = got_a[base + i];
        foreach (exp_bits[i]) ev[i] = exp_bits[i];
        check({tag, ":chain_bits"}, gv, ev);
        check({tag, ":busy_low"}, busy_a, 1'b0);
        check({tag, ":ready_low"}, ready_a, 1'b0);
        check({tag, ":error"}, err_a, bad & CRC_ON);
        repeat (3) @(negedge clk);
        check({tag, ":done_held"}, done_a, 1'b1);
    endtask

    initial begin
        int base, t;
        logic [63:0] gv;

        // Reset state.
        @(negedge clk);
        check("rst:ready", ready_a, 1'b0);
        check("rst:head", head_a, 1'b0);
        check("rst:pclk", pclk_a, 1'b0);
        check("rst:busy", busy_a, 1'b0);
        check("rst:done", done_a, 1'b0);
        check("rst:error", err_a, 1'b0);
        check("rst:b_done", done_b, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle:ready", ready_a, 1'b0);

        // Directed example, valid held high.
        words_a = {8'hA5, 8'h3C, 8'h0F};
        run_load_a("basic", 0, 1'b0, 1'b0);

        // Backpressure between words 1 and 2.
        run_load_a("backpressure", 5, 1'b0, 1'b0);

        // start pulsed while shifting.
        run_load_a("start_in_shift", 0, 1'b1, 1'b0);

        // Wrong trailing CRC (only meaningful when the CRC check is built in).
        run_load_a("bad_crc", 0, 1'b0, 1'b1);

        // Asynchronous reset during bit 11, then a fresh load.
        base = got_a.size();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        data_a  = 8'h5A;
        valid_a = 1'b1;
        t = 0;
        while (got_a.size() - base < 11 && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("midreset:reached_bit11", got_a.size() - base, 11);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset:ready", ready_a, 1'b0);
        check("midreset:head", head_a, 1'b0);
        check("midreset:pclk", pclk_a, 1'b0);
        check("midreset:busy", busy_a, 1'b0);
        check("midreset:done", done_a, 1'b0);
        check("midreset:error", err_a, 1'b0);
        valid_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset:stays_idle", busy_a, 1'b0);
        words_a = {8'h96, 8'hE1, 8'h73};
        run_load_a("after_reset", 0, 1'b0, 1'b0);

        // Randomized loads.
        for (int k = 0; k < 4; k++) begin
            words_a = {};
            repeat (3) words_a.push_back(8'($urandom));
            run_load_a($sformatf("rand%0d", k), (k % 2 == 1) ? int'($urandom_range(1, 6)) : 0,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // 8-bit chain, single all-ones word; done holds until the next start.
        base = got_b.size();
        @(negedge clk);
        start_b = 1'b1;
        data_b  = 8'hFF;
        valid_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        t = 0;
        while (!done_b && t < LIM) begin
            @(negedge clk);
            t++;
        end
        check("b:done_seen", done_b, 1'b1);
        check("b:pulse_count", got_b.size() - base, LB);
        gv = '0;
        for (int i = 0; i < LB && base + i < got_b.size(); i++) gv[i] = got_b[base + i];
        check("b:chain_bits", gv, 64'hFF);
        check("b:error_no_crc", err_b, 1'b0 | (err_b & CRC_ON));
        repeat (5) @(negedge clk);
        check("b:done_held", done_b, 1'b1);
        check("b:busy_low", busy_b, 1'b0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("b:done_cleared_by_start", done_b, 1'b0);
        check("b:busy_after_restart", busy_b, 1'b1);
        valid_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
